accum_bytes_datapath: RTL and testbench
=======================================

Name: accum_bytes_datapath

Overview:
- Execute-stage consumer of the AccumBytes multi-cycle sequence (opcode 5'b01000).
- Follows the cycle count and stall produced by the execute controller and selects one of four neighbour words per cycle.
- Sums the four bytes of each selected word into an accumulator.
- After the fourth word it delivers a 32-bit zero-extended result with a one-cycle valid strobe to the writeback path.

Parameters:
- OPCODE, 5'b01000, AccumBytes opcode matched on controlInExOpA.
- DATA_W, 32, neighbour word width (4 bytes, fixed).
- ACC_W, 12, accumulator width (max 16 x 255 = 4080 fits).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- controlInExOpA  in  5  opcode presented to execute stage.
- controlInExCycleCnt  in  3  sequence count from execute controller (0..3).
- stall  in  1  pipeline hold; freezes this block.
- flush  in  1  pipeline kill; aborts any sequence.
- neighborWord0  in  32  neighbour word selected at count 0.
- neighborWord1  in  32  neighbour word selected at count 1.
- neighborWord2  in  32  neighbour word selected at count 2.
- neighborWord3  in  32  neighbour word selected at count 3.
- resultOut  out  32  final byte sum, zero-extended; holds the last result.
- resultValid  out  1  result strobe.
- busy  out  1  high while in ACCUM.
- errSeq  out  1  one-cycle pulse on a count sequencing violation.

Behaviour:
- Reset (rst low, async): state=IDLE, acc=0, expectCnt=0, resultOut=0, resultValid=0, busy=0, errSeq=0.
- Byte sum: unsigned sum of the 4 bytes of the selected word, each zero-extended. Selection is neighborWord[controlInExCycleCnt]. Range 0..1020.
- Arithmetic: acc is ACC_W bits; overflow is impossible by construction. resultOut = {20'b0, acc_final}.
- Priority: flush > stall > normal operation.
- Flush (any state):
  - Next state IDLE; acc and expectCnt cleared; resultValid=0.
  - resultOut keeps its previous value; no errSeq.
- Stall (flush low): all registers hold. resultValid stays asserted if already asserted. errSeq=0.
- IDLE:
  - Start condition: opA==OPCODE and cnt==0.
  - On start: acc<=bytesum(word0), expectCnt<=1, go to ACCUM.
  - opA==OPCODE with cnt!=0: errSeq pulse, stay IDLE.
- ACCUM (busy=1):
  - cnt==expectCnt and cnt<3: acc<=acc+bytesum, expectCnt++.
  - cnt==3==expectCnt: resultOut<=acc+bytesum(word3), acc<=0, go to DONE.
  - cnt!=expectCnt: errSeq pulse, acc cleared, go to IDLE, no result.
- DONE:
  - resultValid=1 for exactly one unstalled cycle, then IDLE.
  - Back-to-back: a start condition in DONE is accepted in the same cycle (load acc from word0, go to ACCUM) while resultValid is still high.
- Latency:
  - Start at cycle T with no stalls → resultOut updated and state DONE at T+4 edge.
  - resultValid high during cycle T+4, low at T+5 unless a stall holds it.
- Outputs are registered except busy, which is decoded from state.
- Reset asserted mid-sequence: immediate return to reset values; partial acc discarded.

Test Plan:
- Basic: word0=0x01020304, word1=0xFFFFFFFF, word2=0x00000000, word3=0x80808080, cnt 0,1,2,3 unstalled → resultOut=0x00000606, resultValid high exactly one cycle, busy high 3 cycles.
- Max value: all words 0xFFFFFFFF → resultOut=0x00000FF0, no overflow.
- Stall mid-sequence: stall high 2 cycles while cnt=2 → acc frozen; same final 0x606; resultValid high during a stall cycle stays high until stall deasserts.
- Flush at cnt=2 → busy drops next cycle, no resultValid, resultOut keeps the prior value. A new sequence then computes correctly from zero.
- Sequencing error: cnt goes 0,1,3 → errSeq one-cycle pulse, state IDLE, no resultValid. Separately, opA=OPCODE with cnt=2 in IDLE → errSeq pulse.
- Back-to-back sequences plus async reset:
  - Second start on the DONE cycle → two results (0x606, then 0x0FF0 for all-0xFF words) with resultValid in consecutive sequences.
  - rst low mid-ACCUM → all outputs 0 asynchronously before the next clock edge.

Source files
------------

// File: rtl/accum_bytes_datapath.sv
// Execute-stage datapath for the AccumBytes sequence: sums the four bytes of
// one neighbour word per cycle and strobes out the total after the fourth word.
module accum_bytes_datapath #(
  parameter logic [4:0] OPCODE = 5'b01000,
  parameter int         DATA_W = 32,
  parameter int         ACC_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        controlInExOpA,
  input  logic [2:0]        controlInExCycleCnt,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] neighborWord0,
  input  logic [DATA_W-1:0] neighborWord1,
  input  logic [DATA_W-1:0] neighborWord2,
  input  logic [DATA_W-1:0] neighborWord3,
  output logic [DATA_W-1:0] resultOut,
  output logic              resultValid,
  output logic              busy,
  output logic              errSeq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [1:0]         expect_q, expect_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic [DATA_W-1:0]  sel_word;
  logic [9:0]         word_sum;
  logic [ACC_W-1:0]   acc_plus;
  logic               is_op, start, bad_start, cnt_match;

  function automatic logic [9:0] byte_sum(input logic [31:0] w);
    return 10'(w[7:0]) + 10'(w[15:8]) + 10'(w[23:16]) + 10'(w[31:24]);
  endfunction

  always_comb begin
    case (controlInExCycleCnt[1:0])
      2'd0:    sel_word = neighborWord0;
      2'd1:    sel_word = neighborWord1;
      2'd2:    sel_word = neighborWord2;
      default: sel_word = neighborWord3;
    endcase
  end

  assign word_sum  = byte_sum(sel_word);
  assign acc_plus  = acc_q + ACC_W'(word_sum);
  assign is_op     = (controlInExOpA == OPCODE);
  assign start     = is_op && (controlInExCycleCnt == 3'd0);
  assign bad_start = is_op && (controlInExCycleCnt != 3'd0);
  assign cnt_match = (controlInExCycleCnt == {1'b0, expect_q});

  always_comb begin
    // NOTE: every next-state signal is defaulted to hold first so no path through
    // the case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    expect_d = expect_q;
    result_d = result_q;
    valid_d  = valid_q;
    err_d    = 1'b0;

    if (flush) begin
      state_d  = S_IDLE;
      acc_d    = '0;
      expect_d = '0;
      valid_d  = 1'b0;
    end else if (!stall) begin
      valid_d = 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          // A start on the DONE cycle is taken immediately for back-to-back use.
          state_d = S_IDLE;
          if (start) begin
            acc_d    = ACC_W'(word_sum);
            expect_d = 2'd1;
            state_d  = S_ACCUM;
          end else if (bad_start) begin
            err_d = 1'b1;
          end
        end
        S_ACCUM: begin
          if (!cnt_match) begin
            err_d    = 1'b1;
            acc_d    = '0;
            expect_d = '0;
            state_d  = S_IDLE;
          end else if (expect_q == 2'd3) begin
            result_d = acc_plus;
            valid_d  = 1'b1;
            acc_d    = '0;
            expect_d = '0;
            state_d  = S_DONE;
          end else begin
            acc_d    = acc_plus;
            expect_d = expect_q + 2'd1;
          end
        end
        default: begin
          state_d  = S_IDLE;
          acc_d    = '0;
          expect_d = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      expect_q <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      expect_q <= expect_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign resultOut   = {{(DATA_W-ACC_W){1'b0}}, result_q};
  assign resultValid = valid_q;
  assign busy        = (state_q == S_ACCUM);
  assign errSeq      = err_q;

endmodule

// File: tb/tb_accum_bytes_datapath.sv
// Scoreboard bench for accum_bytes_datapath: directed sequences push expected
// results; a negedge monitor pops and compares on each resultValid strobe.
module tb_accum_bytes_datapath;

  localparam logic [4:0] OPCODE = 5'b01000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  controlInExOpA;
  logic [2:0]  controlInExCycleCnt;
  logic        stall, flush;
  logic [31:0] neighborWord0, neighborWord1, neighborWord2, neighborWord3;
  logic [31:0] resultOut;
  logic        resultValid, busy, errSeq;

  int passed = 0;
  int total  = 0;
  int valid_cnt = 0, busy_cnt = 0, err_cnt = 0;
  logic valid_prev = 1'b0;
  logic [31:0] exp_q[$];

  accum_bytes_datapath dut (
    .clk                 (clk),
    .rst                 (rst),
    .controlInExOpA      (controlInExOpA),
    .controlInExCycleCnt (controlInExCycleCnt),
    .stall               (stall),
    .flush               (flush),
    .neighborWord0       (neighborWord0),
    .neighborWord1       (neighborWord1),
    .neighborWord2       (neighborWord2),
    .neighborWord3       (neighborWord3),
    .resultOut           (resultOut),
    .resultValid         (resultValid),
    .busy                (busy),
    .errSeq              (errSeq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: counts strobe/busy/err cycles and scores each new result.
  always @(negedge clk) begin
    if (rst) begin
      if (resultValid) valid_cnt++;
      if (busy)        busy_cnt++;
      if (errSeq)      err_cnt++;
      if (resultValid && !valid_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_result: got 0x%08h with no expected entry", resultOut);
        end else begin
          check("sb_result", resultOut, exp_q.pop_front());
        end
      end
      valid_prev = resultValid;
    end else begin
      valid_prev = 1'b0;
    end
  end

  task automatic clear_counts();
    valid_cnt = 0;
    busy_cnt  = 0;
    err_cnt   = 0;
  endtask

  task automatic set_words(input logic [31:0] w0, w1, w2, w3);
    neighborWord0 = w0;
    neighborWord1 = w1;
    neighborWord2 = w2;
    neighborWord3 = w3;
  endtask

  task automatic step(input logic [2:0] c, input logic op_en, input logic st, input logic fl);
    controlInExOpA      = op_en ? OPCODE : 5'h00;
    controlInExCycleCnt = c;
    stall               = st;
    flush               = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_seq(input logic [31:0] expected);
    exp_q.push_back(expected);
    for (int c = 0; c < 4; c++) step(3'(c), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_basic();
    set_words(32'h01020304, 32'hFFFFFFFF, 32'h00000000, 32'h80808080);
  endtask

  task automatic set_max();
    set_words(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
  endtask

  initial begin
    rst = 1'b0;
    controlInExOpA = '0; controlInExCycleCnt = '0; stall = 1'b0; flush = 1'b0;
    set_basic();
    #12;
    check("rst_result", resultOut, 32'h0);
    check("rst_valid",  32'(resultValid), 32'h0);
    check("rst_busy",   32'(busy), 32'h0);
    check("rst_err",    32'(errSeq), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic: 10 + 1020 + 0 + 512 = 1542
    clear_counts();
    run_seq(32'h00000606);
    check("basic_result_now", resultOut, 32'h00000606);
    check("basic_valid_now",  32'(resultValid), 32'h1);
    idle(3);
    check("basic_valid_cycles", 32'(valid_cnt), 32'd1);
    check("basic_busy_cycles",  32'(busy_cnt), 32'd3);
    check("basic_err_cycles",   32'(err_cnt), 32'd0);

    // Max: 16 x 255 = 4080
    set_max();
    clear_counts();
    run_seq(32'h00000FF0);
    idle(2);
    check("max_valid_cycles", 32'(valid_cnt), 32'd1);

    // Stall for two cycles at cnt=2, then stall the DONE cycle twice
    set_basic();
    clear_counts();
    exp_q.push_back(32'h00000606);
    step(3'd0, 1'b1, 1'b0, 1'b0);
    step(3'd1, 1'b1, 1'b0, 1'b0);
    step(3'd2, 1'b1, 1'b1, 1'b0);
    step(3'd2, 1'b1, 1'b1, 1'b0);
    check("stall_busy_held", 32'(busy), 32'h1);
    step(3'd2, 1'b1, 1'b0, 1'b0);
    step(3'd3, 1'b1, 1'b0, 1'b0);
    check("stall_result", resultOut, 32'h00000606);
    step(3'd0, 1'b0, 1'b1, 1'b0);
    check("stall_valid_held1", 32'(resultValid), 32'h1);
    step(3'd0, 1'b0, 1'b1, 1'b0);
    check("stall_valid_held2", 32'(resultValid), 32'h1);
    step(3'd0, 1'b0, 1'b0, 1'b0);
    check("stall_valid_drop", 32'(resultValid), 32'h0);
    idle(1);
    check("stall_valid_cycles", 32'(valid_cnt), 32'd3);
    check("stall_busy_cycles",  32'(busy_cnt), 32'd5);

    // Flush at cnt=2: aborts, result keeps 0x606, fresh sequence from zero
    clear_counts();
    step(3'd0, 1'b1, 1'b0, 1'b0);
    step(3'd1, 1'b1, 1'b0, 1'b0);
    step(3'd2, 1'b1, 1'b0, 1'b1);
    check("flush_busy_drop", 32'(busy), 32'h0);
    check("flush_result_kept", resultOut, 32'h00000606);
    idle(2);
    check("flush_no_valid", 32'(valid_cnt), 32'd0);
    check("flush_no_err",   32'(err_cnt), 32'd0);
    set_max();
    run_seq(32'h00000FF0);
    idle(2);

    // Sequencing error: cnt 0,1,3
    set_basic();
    clear_counts();
    step(3'd0, 1'b1, 1'b0, 1'b0);
    step(3'd1, 1'b1, 1'b0, 1'b0);
    step(3'd3, 1'b1, 1'b0, 1'b0);
    check("seqerr_pulse", 32'(errSeq), 32'h1);
    check("seqerr_idle",  32'(busy), 32'h0);
    idle(2);
    check("seqerr_err_cycles", 32'(err_cnt), 32'd1);
    check("seqerr_no_valid",   32'(valid_cnt), 32'd0);
    check("seqerr_result_kept", resultOut, 32'h00000FF0);

    // Opcode with cnt=2 while idle
    clear_counts();
    step(3'd2, 1'b1, 1'b0, 1'b0);
    check("badstart_pulse", 32'(errSeq), 32'h1);
    idle(2);
    check("badstart_err_cycles", 32'(err_cnt), 32'd1);
    check("badstart_busy", 32'(busy_cnt), 32'd0);

    // Back-to-back: second start on the DONE cycle
    clear_counts();
    run_seq(32'h00000606);
    set_max();
    run_seq(32'h00000FF0);
    idle(2);
    check("b2b_valid_cycles", 32'(valid_cnt), 32'd2);
    check("b2b_busy_cycles",  32'(busy_cnt), 32'd6);

    // Async reset mid-ACCUM
    set_basic();
    step(3'd0, 1'b1, 1'b0, 1'b0);
    step(3'd1, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("arst_result", resultOut, 32'h0);
    check("arst_busy",   32'(busy), 32'h0);
    check("arst_valid",  32'(resultValid), 32'h0);
    check("arst_err",    32'(errSeq), 32'h0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    idle(1);
    clear_counts();
    run_seq(32'h00000606);
    idle(2);
    check("post_rst_valid_cycles", 32'(valid_cnt), 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
